// File: rtl/candidate_sorter.sv
// candidate_sorter: keeps the top-K scored (theta, phi) candidates of a stage and publishes them in descending score order
module candidate_sorter #(
    parameter int N_MAX   = 10,
    parameter int ANG_W   = 12,
    parameter int SCORE_W = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     score_valid,
    input  logic                     score_last,
    input  logic [SCORE_W-1:0]       score,
    input  logic [ANG_W-1:0]         score_theta,
    input  logic [ANG_W-1:0]         score_phi,
    input  logic [3:0]               compare_num,
    output logic [N_MAX*2*ANG_W-1:0] candidate_angle_buffer,
    output logic [3:0]               candidate_count,
    output logic [SCORE_W-1:0]       best_score,
    output logic                     sorted_rdy
);
    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_PUBLISH = 2'd1;
    localparam logic [1:0] S_RDY     = 2'd2;

    logic [1:0]               r_state;
    logic [SCORE_W-1:0]       r_sc [N_MAX];
    logic [ANG_W-1:0]         r_th [N_MAX];
    logic [ANG_W-1:0]         r_ph [N_MAX];
    logic [3:0]               r_wcnt;
    logic [N_MAX*2*ANG_W-1:0] r_buf;
    logic [3:0]               r_cnt;
    logic [SCORE_W-1:0]       r_best;
    logic                     r_rdy;
    logic [3:0]               w_k;
    logic [3:0]               w_pos;
    logic                     w_take;
    logic                     w_ins;
    logic                     w_wipe;

    // Effective K, insertion slot (ties rank below earlier arrivals) and accept qualifiers
    always_comb begin
        w_k = (compare_num == 4'd0) ? 4'd1 : (compare_num > 4'(N_MAX)) ? 4'(N_MAX) : compare_num;
        w_pos = '0;
        for (int i = 0; i < N_MAX; i++)
            if (4'(i) < r_wcnt && r_sc[i] >= score) w_pos = w_pos + 4'd1;
        w_take = (r_state == S_COLLECT) && score_valid && !clear;
        w_ins  = w_take && (w_pos < w_k);
        w_wipe = (r_state == S_PUBLISH) || ((r_state == S_COLLECT) && clear);
    end

    // Working list: parallel compare/shift insert; emptied by clear or after publishing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || w_wipe) begin
            r_wcnt <= '0;
            for (int i = 0; i < N_MAX; i++) begin
                r_sc[i] <= '0;
                r_th[i] <= '0;
                r_ph[i] <= '0;
            end
        end else if (w_ins) begin
            if (w_pos == 4'd0) begin
                r_sc[0] <= score;
                r_th[0] <= score_theta;
                r_ph[0] <= score_phi;
            end
            for (int i = 1; i < N_MAX; i++) begin
                if (4'(i) == w_pos) begin
                    r_sc[i] <= score;
                    r_th[i] <= score_theta;
                    r_ph[i] <= score_phi;
                end else if (4'(i) > w_pos && 4'(i) < w_k) begin
                    r_sc[i] <= r_sc[i-1];
                    r_th[i] <= r_th[i-1];
                    r_ph[i] <= r_ph[i-1];
                end
            end
            r_wcnt <= (r_wcnt + 4'd1 > w_k) ? w_k : r_wcnt + 4'd1;
        end
    end

    // Stage sequencing: COLLECT until the last score, one PUBLISH cycle, one RDY cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_COLLECT;
        else
            r_state <= (r_state == S_COLLECT) ? ((w_take && score_last) ? S_PUBLISH : S_COLLECT) :
                       (r_state == S_PUBLISH) ? S_RDY : S_COLLECT;
    end

    // Published list loads only when leaving PUBLISH; the ready pulse trails RDY by one register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf  <= '0;
            r_cnt  <= '0;
            r_best <= '0;
            r_rdy  <= 1'b0;
        end else begin
            r_rdy <= (r_state == S_RDY);
            if (r_state == S_PUBLISH) begin
                for (int i = 0; i < N_MAX; i++)
                    r_buf[i*2*ANG_W +: 2*ANG_W] <= {r_th[i], r_ph[i]};
                r_cnt  <= r_wcnt;
                r_best <= r_sc[0];
            end
        end
    end

    assign candidate_angle_buffer = r_buf;
    assign candidate_count        = r_cnt;
    assign best_score             = r_best;
    assign sorted_rdy             = r_rdy;
endmodule

// File: tb/tb_candidate_sorter.sv
// tb_candidate_sorter: randomized and directed checks of candidate_sorter against a sort-all-then-truncate reference model
module tb_candidate_sorter;
    logic         clk = 0, rst = 1, clear = 0, score_valid = 0, score_last = 0;
    logic [19:0]  score = 0;
    logic [11:0]  score_theta = 0, score_phi = 0;
    logic [3:0]   compare_num = 0;
    logic [239:0] candidate_angle_buffer;
    logic [3:0]   candidate_count;
    logic [19:0]  best_score;
    logic         sorted_rdy;
    int n_cmp = 0, n_err = 0;

    typedef struct {logic [19:0] s; logic [11:0] t; logic [11:0] p;} cand_t;
    cand_t q[$];
    logic [239:0] e_buf;
    logic [3:0]   e_cnt;
    logic [19:0]  e_best;

    always #5 clk = ~clk;

    candidate_sorter dut (
        .clk(clk), .rst(rst), .clear(clear), .score_valid(score_valid), .score_last(score_last),
        .score(score), .score_theta(score_theta), .score_phi(score_phi), .compare_num(compare_num),
        .candidate_angle_buffer(candidate_angle_buffer), .candidate_count(candidate_count),
        .best_score(best_score), .sorted_rdy(sorted_rdy)
    );

    // Reference: all stage candidates in arrival order, repeatedly pick the highest (earliest on ties), keep K
    function automatic void model(input int cn);
        cand_t pool[$];
        int k, bi;
        pool = q;
        k = (cn == 0) ? 1 : (cn > 10) ? 10 : cn;
        e_buf = '0; e_cnt = '0; e_best = '0;
        for (int r = 0; r < k && pool.size() > 0; r++) begin
            bi = 0;
            for (int j = 1; j < pool.size(); j++) if (pool[j].s > pool[bi].s) bi = j;
            e_buf[r*24 +: 24] = {pool[bi].t, pool[bi].p};
            if (r == 0) e_best = pool[bi].s;
            e_cnt = e_cnt + 4'd1;
            pool.delete(bi);
        end
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic v, input logic l, input logic c, input logic [19:0] s, input logic [11:0] t, input logic [11:0] p);
        score_valid = v; score_last = l; clear = c; score = s; score_theta = t; score_phi = p;
        tick();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic [19:0] s, input logic [11:0] t, input logic [11:0] p, input logic l);
        cand_t c;
        c.s = s; c.t = t; c.p = p;
        q.push_back(c);
        drive(1, l, 0, s, t, p);
    endtask

    task automatic test_reset();
        #1 rst = 0;
        #2;
        n_cmp++; if (candidate_angle_buffer !== '0) begin n_err++; $display("FAIL reset_buf got=%h exp=0", candidate_angle_buffer); end
        n_cmp++; if (candidate_count !== 4'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", candidate_count); end
        n_cmp++; if (best_score !== 20'd0) begin n_err++; $display("FAIL reset_best got=%0d exp=0", best_score); end
        n_cmp++; if (sorted_rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy got=%b exp=0", sorted_rdy); end
        tick(); tick();
        rst = 1;
        for (int i = 0; i < 20; i++) begin
            idle();
            n_cmp++; if (sorted_rdy !== 1'b0) begin n_err++; $display("FAIL idle_rdy cycle=%0d got=%b exp=0", i, sorted_rdy); end
        end
        n_cmp++; if ({candidate_angle_buffer, candidate_count, best_score} !== '0) begin n_err++; $display("FAIL idle_outputs got=%h exp=0", {candidate_angle_buffer, candidate_count, best_score}); end
    endtask

    task automatic test_ties();
        compare_num = 3; q.delete();
        push(5, 1, 1, 0); push(9, 2, 2, 0); push(7, 3, 3, 0); push(9, 4, 4, 0); push(2, 5, 5, 1);
        model(3);
        n_cmp++; if (sorted_rdy !== 1'b0) begin n_err++; $display("FAIL ties_rdy_k got=%b exp=0", sorted_rdy); end
        idle();
        n_cmp++; if (candidate_angle_buffer !== e_buf) begin n_err++; $display("FAIL ties_buf got=%h exp=%h", candidate_angle_buffer, e_buf); end
        n_cmp++; if (candidate_angle_buffer[71:0] !== {12'd3, 12'd3, 12'd4, 12'd4, 12'd2, 12'd2}) begin n_err++; $display("FAIL ties_order got=%h exp=003003004004002002", candidate_angle_buffer[71:0]); end
        n_cmp++; if (candidate_count !== 4'd3) begin n_err++; $display("FAIL ties_cnt got=%0d exp=3", candidate_count); end
        n_cmp++; if (best_score !== 20'd9) begin n_err++; $display("FAIL ties_best got=%0d exp=9", best_score); end
        n_cmp++; if (sorted_rdy !== 1'b0) begin n_err++; $display("FAIL ties_rdy_k1 got=%b exp=0", sorted_rdy); end
        idle();
        n_cmp++; if (sorted_rdy !== 1'b1) begin n_err++; $display("FAIL ties_rdy_k2 got=%b exp=1", sorted_rdy); end
        idle();
        n_cmp++; if (sorted_rdy !== 1'b0) begin n_err++; $display("FAIL ties_rdy_k3 got=%b exp=0", sorted_rdy); end
    endtask

    task automatic test_partial_fill();
        compare_num = 10; q.delete();
        push(100, 12'($urandom), 12'($urandom), 0); push(300, 12'($urandom), 12'($urandom), 0);
        push(200, 12'($urandom), 12'($urandom), 0); push(50, 12'($urandom), 12'($urandom), 1);
        model(10);
        idle();
        n_cmp++; if (candidate_angle_buffer !== e_buf) begin n_err++; $display("FAIL partial_buf got=%h exp=%h", candidate_angle_buffer, e_buf); end
        n_cmp++; if (candidate_angle_buffer[239:96] !== '0) begin n_err++; $display("FAIL partial_upper got=%h exp=0", candidate_angle_buffer[239:96]); end
        n_cmp++; if (candidate_count !== 4'd4) begin n_err++; $display("FAIL partial_cnt got=%0d exp=4", candidate_count); end
        n_cmp++; if (best_score !== 20'd300) begin n_err++; $display("FAIL partial_best got=%0d exp=300", best_score); end
        idle(); idle();
    endtask

    task automatic test_clear();
        compare_num = 6; q.delete();
        push(40, 1, 2, 0); push(60, 3, 4, 0); push(80, 5, 6, 0);
        drive(0, 0, 1, 0, 0, 0);
        q.delete();
        drive(1, 0, 1, 999, 7, 7);
        push(10, 8, 9, 0); push(20, 10, 11, 1);
        model(6);
        idle();
        n_cmp++; if (candidate_angle_buffer !== e_buf) begin n_err++; $display("FAIL clear_buf got=%h exp=%h", candidate_angle_buffer, e_buf); end
        n_cmp++; if (candidate_count !== 4'd2) begin n_err++; $display("FAIL clear_cnt got=%0d exp=2", candidate_count); end
        n_cmp++; if (best_score !== 20'd20) begin n_err++; $display("FAIL clear_best got=%0d exp=20", best_score); end
        idle(); idle();
    endtask

    task automatic test_back_to_back();
        logic [239:0] a_buf;
        logic [3:0]   a_cnt;
        compare_num = 4; q.delete();
        for (int i = 0; i < 6; i++) push(20'($urandom_range(0, 9)), 12'($urandom), 12'($urandom), i == 5);
        model(4);
        a_buf = e_buf; a_cnt = e_cnt;
        drive(1, 0, 0, 20'hFFFFF, 12'hABC, 12'hDEF);
        drive(1, 1, 0, 20'hFFFFE, 12'h123, 12'h456);
        n_cmp++; if (sorted_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_rdy got=%b exp=1", sorted_rdy); end
        idle();
        q.delete();
        push(20'd3, 12'd1, 12'd1, 0); push(20'd8, 12'd2, 12'd2, 0);
        n_cmp++; if (candidate_angle_buffer !== a_buf || candidate_count !== a_cnt) begin n_err++; $display("FAIL b2b_hold got=%h/%0d exp=%h/%0d", candidate_angle_buffer, candidate_count, a_buf, a_cnt); end
        push(20'd5, 12'd3, 12'd3, 1);
        model(4);
        idle();
        n_cmp++; if (candidate_angle_buffer !== e_buf) begin n_err++; $display("FAIL b2b_buf got=%h exp=%h", candidate_angle_buffer, e_buf); end
        n_cmp++; if (best_score !== 20'd8) begin n_err++; $display("FAIL b2b_best got=%0d exp=8", best_score); end
        idle(); idle();
    endtask

    task automatic test_reset_mid();
        compare_num = 2; q.delete();
        push(20'd77, 12'd9, 12'd9, 0); push(20'd66, 12'd8, 12'd8, 0);
        #2 rst = 0;
        #1;
        n_cmp++; if ({candidate_angle_buffer, candidate_count, best_score, sorted_rdy} !== '0) begin n_err++; $display("FAIL rstmid_outputs got=%h exp=0", {candidate_angle_buffer, candidate_count, best_score, sorted_rdy}); end
        tick();
        rst = 1;
        q.delete();
        push(20'd1, 12'd4, 12'd4, 0); push(20'd3, 12'd5, 12'd5, 0); push(20'd2, 12'd6, 12'd6, 1);
        model(2);
        idle();
        n_cmp++; if (candidate_angle_buffer !== e_buf) begin n_err++; $display("FAIL rstmid_buf got=%h exp=%h", candidate_angle_buffer, e_buf); end
        n_cmp++; if (candidate_count !== e_cnt || best_score !== e_best) begin n_err++; $display("FAIL rstmid_cnt_best got=%0d/%0d exp=%0d/%0d", candidate_count, best_score, e_cnt, e_best); end
        idle(); idle();
    endtask

    task automatic test_random();
        int cn, n;
        for (int s = 0; s < 12; s++) begin
            cn = $urandom_range(0, 15); n = $urandom_range(1, 14);
            compare_num = 4'(cn); q.delete();
            for (int i = 0; i < n; i++) begin
                push((s % 2) ? 20'($urandom_range(0, 6)) : 20'($urandom), 12'($urandom), 12'($urandom), i == n - 1);
                n_cmp++; if (sorted_rdy !== 1'b0) begin n_err++; $display("FAIL rand_rdy_early stage=%0d got=%b exp=0", s, sorted_rdy); end
            end
            model(cn);
            idle();
            n_cmp++; if (candidate_angle_buffer !== e_buf) begin n_err++; $display("FAIL rand_buf stage=%0d got=%h exp=%h", s, candidate_angle_buffer, e_buf); end
            n_cmp++; if (candidate_count !== e_cnt) begin n_err++; $display("FAIL rand_cnt stage=%0d got=%0d exp=%0d", s, candidate_count, e_cnt); end
            n_cmp++; if (best_score !== e_best) begin n_err++; $display("FAIL rand_best stage=%0d got=%0d exp=%0d", s, best_score, e_best); end
            idle();
            n_cmp++; if (sorted_rdy !== 1'b1) begin n_err++; $display("FAIL rand_rdy stage=%0d got=%b exp=1", s, sorted_rdy); end
            idle();
        end
    endtask

    initial begin
        test_reset();
        test_ties();
        test_partial_fill();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
